// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory stage: word load/store over req/ack, registered write-back bundle (optional MEM_TIMEOUT_EN)
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              regw_in,
  input  logic              memtoreg,
  input  logic [3:0]        rd_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              wb_valid,
  output logic              wb_regw,
  output logic [3:0]        wb_rd,
  output logic [DATA_W-1:0] wb_result,
  output logic              mem_err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state;
  logic              lat_regw;
  logic              lat_use_mem;  // load with memtoreg: result comes from dmem_rdata
  logic [3:0]        lat_rd;
  logic [DATA_W-1:0] lat_alu;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt;
`endif

  // Upstream is held for every cycle an access is outstanding, including the ack cycle.
  assign stall = (state == ACCESS);

  // Stage FSM: accepts instructions in IDLE, holds the memory request in ACCESS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      wb_valid    <= 1'b0;
      wb_regw     <= 1'b0;
      wb_rd       <= '0;
      wb_result   <= '0;
      lat_regw    <= 1'b0;
      lat_use_mem <= 1'b0;
      lat_rd      <= '0;
      lat_alu     <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt         <= '0;
      mem_err     <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      mem_err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (mem_read || mem_write) begin
              // Read+write together is a store, so the read path is only used for pure loads.
              state       <= ACCESS;
              dmem_req    <= 1'b1;
              dmem_we     <= mem_write;
              dmem_addr   <= alu_result;
              dmem_wdata  <= store_data;
              lat_regw    <= regw_in;
              lat_rd      <= rd_in;
              lat_alu     <= alu_result;
              lat_use_mem <= mem_read && !mem_write && memtoreg;
`ifdef MEM_TIMEOUT_EN
              cnt         <= '0;
`endif
            end else begin
              wb_valid  <= 1'b1;
              wb_regw   <= regw_in;
              wb_rd     <= rd_in;
              wb_result <= alu_result;
            end
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            state     <= IDLE;
            dmem_req  <= 1'b0;
            wb_valid  <= 1'b1;
            wb_regw   <= lat_regw;
            wb_rd     <= lat_rd;
            wb_result <= lat_use_mem ? dmem_rdata : lat_alu;
          end
`ifdef MEM_TIMEOUT_EN
          else begin
            cnt <= cnt + 1'b1;
            // This is the TIMEOUT-th cycle without ack: abort with a no-write write-back.
            if (cnt == CNT_W'(TIMEOUT - 1)) begin
              state    <= IDLE;
              dmem_req <= 1'b0;
              wb_valid <= 1'b1;
              wb_regw  <= 1'b0;
              wb_rd    <= lat_rd;
              mem_err  <= 1'b1;
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef MEM_TIMEOUT_EN
  assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage: vector table, corner sequences, randomized model check
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, mem_read, mem_write, regw_in, memtoreg;
  logic [3:0]  rd_in;
  logic [31:0] alu_result, store_data;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid, wb_regw;
  logic [3:0]  wb_rd;
  logic [31:0] wb_result;
  logic        mem_err;

  int vectors = 0;
  int miscompares = 0;

  mem_stage #(.DATA_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .mem_read(mem_read), .mem_write(mem_write),
    .regw_in(regw_in), .memtoreg(memtoreg), .rd_in(rd_in),
    .alu_result(alu_result), .store_data(store_data),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .wb_valid(wb_valid), .wb_regw(wb_regw), .wb_rd(wb_rd),
    .wb_result(wb_result), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    in_valid = 0; mem_read = 0; mem_write = 0; regw_in = 0; memtoreg = 0;
    rd_in = 0; alu_result = 0; store_data = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
  endtask

  typedef struct {
    logic        iv, mr, mw, regw, m2r;
    logic [3:0]  rd;
    logic [31:0] alu, sdata;
    logic        ack;
    logic [31:0] rdata;
    logic        e_stall, e_req, e_we;
    logic [31:0] e_addr, e_wdata;
    logic        e_wbv, e_regw;
    logic [3:0]  e_rd;
    logic [31:0] e_res;
  } vec_t;

  vec_t tbl [14];

  // memory contents seen by the randomized responder / model
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return ~a;
  endfunction

  // transaction-level model state
  logic        m_busy, m_we, m_regw, m_use_mem;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_rd;
  logic        exp_wbv, exp_regw;
  logic [3:0]  exp_rd;
  logic [31:0] exp_res;
  int          ack_delay, waited;

  initial begin
    int n;
    int op;

    //                iv mr mw rw m2r rd  alu          sdata          ack rdata          st rq we addr   wdata          wbv rw rd  res
    tbl[0]  = '{1, 0, 0, 1, 0, 3,  32'h10, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,  32'h0,        1, 1, 3,  32'h10};
    tbl[1]  = '{1, 0, 0, 1, 0, 4,  32'h20, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,  32'h0,        1, 1, 4,  32'h20};
    tbl[2]  = '{1, 0, 0, 0, 0, 5,  32'h30, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,  32'h0,        1, 0, 5,  32'h30};
    tbl[3]  = '{1, 1, 0, 1, 1, 6,  32'h40, 32'h99,       0, 32'h0,        1, 1, 0, 32'h40, 32'h99,       0, 0, 5,  32'h30};
    tbl[4]  = '{1, 0, 0, 1, 0, 7,  32'h70, 32'h77,       0, 32'h0,        1, 1, 0, 32'h40, 32'h99,       0, 0, 5,  32'h30};
    tbl[5]  = '{1, 0, 0, 1, 0, 7,  32'h70, 32'h77,       0, 32'h0,        1, 1, 0, 32'h40, 32'h99,       0, 0, 5,  32'h30};
    tbl[6]  = '{1, 0, 0, 1, 0, 7,  32'h70, 32'h77,       1, 32'hDEADBEEF, 0, 0, 0, 32'h0,  32'h0,        1, 1, 6,  32'hDEADBEEF};
    tbl[7]  = '{1, 0, 0, 1, 0, 7,  32'h70, 32'h77,       0, 32'h0,        0, 0, 0, 32'h0,  32'h0,        1, 1, 7,  32'h70};
    tbl[8]  = '{1, 1, 1, 0, 1, 8,  32'h80, 32'h12345678, 0, 32'h0,        1, 1, 1, 32'h80, 32'h12345678, 0, 0, 7,  32'h70};
    tbl[9]  = '{1, 0, 0, 1, 0, 9,  32'h90, 32'h0,        1, 32'hBAD,      0, 0, 0, 32'h0,  32'h0,        1, 0, 8,  32'h80};
    tbl[10] = '{1, 0, 0, 1, 0, 9,  32'h90, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,  32'h0,        1, 1, 9,  32'h90};
    tbl[11] = '{0, 0, 0, 0, 0, 0,  32'h0,  32'h0,        1, 32'h55,       0, 0, 0, 32'h0,  32'h0,        0, 0, 9,  32'h90};
    tbl[12] = '{1, 1, 0, 1, 0, 10, 32'h44, 32'h5,        0, 32'h0,        1, 1, 0, 32'h44, 32'h5,        0, 0, 9,  32'h90};
    tbl[13] = '{0, 0, 0, 0, 0, 0,  32'h0,  32'h0,        1, 32'hCAFE,     0, 0, 0, 32'h0,  32'h0,        1, 1, 10, 32'h44};

    // ---------------- reset state ----------------
    idle_inputs();
    reset = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_stall", stall, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_we", dmem_we, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_wdata", dmem_wdata, 0);
    chk("rst_wbv", wb_valid, 0);
    chk("rst_regw", wb_regw, 0);
    chk("rst_rd", wb_rd, 0);
    chk("rst_res", wb_result, 0);
    chk("rst_err", mem_err, 0);
    reset = 1;

    // ---------------- vector table ----------------
    for (int i = 0; i < 14; i++) begin
      in_valid = tbl[i].iv; mem_read = tbl[i].mr; mem_write = tbl[i].mw;
      regw_in = tbl[i].regw; memtoreg = tbl[i].m2r; rd_in = tbl[i].rd;
      alu_result = tbl[i].alu; store_data = tbl[i].sdata;
      dmem_ack = tbl[i].ack; dmem_rdata = tbl[i].rdata;
      @(negedge clk);
      chk($sformatf("t%0d_stall", i), stall, tbl[i].e_stall);
      chk($sformatf("t%0d_req", i), dmem_req, tbl[i].e_req);
      if (tbl[i].e_req) begin
        chk($sformatf("t%0d_we", i), dmem_we, tbl[i].e_we);
        chk($sformatf("t%0d_addr", i), dmem_addr, tbl[i].e_addr);
        chk($sformatf("t%0d_wdata", i), dmem_wdata, tbl[i].e_wdata);
      end
      chk($sformatf("t%0d_wbv", i), wb_valid, tbl[i].e_wbv);
      if (tbl[i].e_wbv) chk($sformatf("t%0d_regw", i), wb_regw, tbl[i].e_regw);
      chk($sformatf("t%0d_rd", i), wb_rd, tbl[i].e_rd);
      chk($sformatf("t%0d_res", i), wb_result, tbl[i].e_res);
      chk($sformatf("t%0d_err", i), mem_err, 0);
    end
    idle_inputs();

    // ---------------- reset in the middle of an access ----------------
    in_valid = 1; mem_read = 1; regw_in = 1; memtoreg = 1; rd_in = 2; alu_result = 32'h60;
    @(negedge clk);
    idle_inputs();
    chk("mid_stall_before", stall, 1);
    #2 reset = 0;
    #1;
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_req", dmem_req, 0);
    chk("mid_rst_addr", dmem_addr, 0);
    chk("mid_rst_wbv", wb_valid, 0);
    chk("mid_rst_res", wb_result, 0);
    @(negedge clk);
    reset = 1;
    dmem_ack = 1; dmem_rdata = 32'h1111;
    @(negedge clk);
    dmem_ack = 0;
    chk("stray_stall", stall, 0);
    chk("stray_req", dmem_req, 0);
    chk("stray_wbv", wb_valid, 0);
    chk("stray_rd", wb_rd, 0);
    chk("stray_res", wb_result, 0);

    // ---------------- load with no ack ----------------
    in_valid = 1; mem_read = 1; regw_in = 1; memtoreg = 1; rd_in = 11; alu_result = 32'h100;
    @(negedge clk);
    idle_inputs();
`ifdef MEM_TIMEOUT_EN
    n = 0;
    while (stall === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("to_stall_cycles", n, 15);
    chk("to_stall", stall, 0);
    chk("to_req", dmem_req, 0);
    chk("to_err", mem_err, 1);
    chk("to_wbv", wb_valid, 1);
    chk("to_regw", wb_regw, 0);
    @(negedge clk);
    chk("to_err_pulse", mem_err, 0);
    chk("to_wbv_pulse", wb_valid, 0);
`else
    n = 0;
    repeat (20) begin
      if (stall === 1'b1 && dmem_req === 1'b1) n++;
      @(negedge clk);
    end
    chk("wait_stall_cycles", n, 20);
    chk("wait_err", mem_err, 0);
    dmem_ack = 1; dmem_rdata = 32'h777;
    @(negedge clk);
    dmem_ack = 0;
    chk("wait_wbv", wb_valid, 1);
    chk("wait_regw", wb_regw, 1);
    chk("wait_rd", wb_rd, 11);
    chk("wait_res", wb_result, 32'h777);
    chk("wait_stall", stall, 0);
`endif

    // ---------------- randomized against reference model ----------------
    do_reset();
    m_busy = 0; m_we = 0; m_regw = 0; m_use_mem = 0; m_addr = 0; m_wdata = 0; m_rd = 0;
    exp_wbv = 0; exp_regw = 0; exp_rd = 0; exp_res = 0;
    ack_delay = 0; waited = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      // inputs applied at the previous negedge have been clocked in; compare
      if (cyc > 0) @(negedge clk);
      chk("r_stall", stall, m_busy);
      chk("r_req", dmem_req, m_busy);
      if (m_busy) begin
        chk("r_we", dmem_we, m_we);
        chk("r_addr", dmem_addr, m_addr);
        chk("r_wdata", dmem_wdata, m_wdata);
      end
      chk("r_wbv", wb_valid, exp_wbv);
      if (exp_wbv) chk("r_regw", wb_regw, exp_regw);
      chk("r_rd", wb_rd, exp_rd);
      chk("r_res", wb_result, exp_res);
      chk("r_err", mem_err, 0);

      // new stimulus: a fresh random instruction every cycle, ignored while busy
      op = $urandom_range(0, 5);
      in_valid   = ($urandom_range(0, 3) != 0);
      mem_read   = (op == 0 || op == 1 || op == 3);
      mem_write  = (op == 2 || op == 3);
      regw_in    = $urandom_range(0, 1);
      memtoreg   = $urandom_range(0, 1);
      rd_in      = 4'($urandom_range(0, 15));
      alu_result = 32'($urandom_range(0, 15)) << 2;
      store_data = $urandom;
      if (m_busy) dmem_ack = (waited == ack_delay);
      else        dmem_ack = ($urandom_range(0, 7) == 0);
      dmem_rdata = (m_busy && dmem_ack) ? mem_rd(m_addr) : $urandom;

      // predict the effect of the coming edge
      exp_wbv = 0;
      if (m_busy) begin
        if (dmem_ack) begin
          m_busy   = 0;
          exp_wbv  = 1;
          exp_regw = m_regw;
          exp_rd   = m_rd;
          exp_res  = m_use_mem ? mem_rd(m_addr) : m_addr;
          if (m_we) mem[m_addr] = m_wdata;
        end else begin
          waited++;
        end
      end else if (in_valid) begin
        if (mem_read || mem_write) begin
          m_busy    = 1;
          m_addr    = alu_result;
          m_we      = mem_write;
          m_wdata   = store_data;
          m_rd      = rd_in;
          m_regw    = regw_in;
          m_use_mem = mem_read && !mem_write && memtoreg;
          ack_delay = $urandom_range(0, 3);
          waited    = 0;
        end else begin
          exp_wbv  = 1;
          exp_regw = regw_in;
          exp_rd   = rd_in;
          exp_res  = alu_result;
        end
      end
    end
    @(negedge clk);
    chk("r_final_wbv", wb_valid, exp_wbv);
    chk("r_final_res", wb_result, exp_res);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
